// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data_memory instance between the core memory stage (port 0) and a
// debug/loader requester (port 1). A request is registered in IDLE, the memory
// strobes are driven for exactly one cycle in ACCESS, and a one-cycle
// acknowledge is returned in RESP. Misaligned requests skip ACCESS and complete
// with an error and no strobe.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   pX_req/we/addr/wdata  (in)          requester X command, held until pX_ack
//   pX_ack/err/rdata      (out)         registered response, granted port only
//   core_stall            (out)         p0_req & ~p0_ack (combinational)
//   mem_read/mem_write    (out)         registered one-cycle memory strobes
//   mem_addr/mem_wdata    (out)         registered memory address / store data
//   mem_rdata             (in)          combinational read data from memory
//
// Build option:
//   DMEM_ARB_RR_EN  defined -> round-robin on simultaneous requests
//                   undefined -> fixed priority, port 0 always wins
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              core_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p0_err_q, p0_err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic              p1_ack_q, p1_ack_d;
    logic              p1_err_q, p1_err_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
`ifdef DMEM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    logic              pick_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [DATA_W-1:0] resp_data_s;

    // Winner selection among the currently raised requests.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        // last_q resets to 1 so that port 0 is favoured first.
        if (p0_req && p1_req) begin
            pick_s = ~last_q;
        end else if (p0_req) begin
            pick_s = 1'b0;
        end else begin
            pick_s = 1'b1;
        end
`else
        if (p0_req) begin
            pick_s = 1'b0;
        end else begin
            pick_s = 1'b1;
        end
`endif
    end

    // Mux the winning request's fields.
    always_comb begin
        if (pick_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Stores complete with zero response data; loads return the memory word.
    always_comb begin
        if (we_q) begin
            resp_data_s = {DATA_W{1'b0}};
        end else begin
            resp_data_s = mem_rdata;
        end
    end

    // Next-state and next-output computation; strobes and responses are pulses.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        p0_ack_d    = 1'b0;
        p0_err_d    = 1'b0;
        p0_rdata_d  = {DATA_W{1'b0}};
        p1_ack_d    = 1'b0;
        p1_err_d    = 1'b0;
        p1_rdata_d  = {DATA_W{1'b0}};
`ifdef DMEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_d = pick_s;
`ifdef DMEM_ARB_RR_EN
                    last_d = pick_s;
`endif
                    if (sel_addr_s[2:0] == 3'b000) begin
                        we_d        = sel_we_s;
                        mem_addr_d  = sel_addr_s;
                        mem_wdata_d = sel_wdata_s;
                        mem_read_d  = ~sel_we_s;
                        mem_write_d = sel_we_s;
                        state_d     = ACCESS;
                    end else begin
                        // Misaligned: answer with an error, memory untouched.
                        if (pick_s) begin
                            p1_ack_d = 1'b1;
                            p1_err_d = 1'b1;
                        end else begin
                            p0_ack_d = 1'b1;
                            p0_err_d = 1'b1;
                        end
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (gnt_q) begin
                    p1_ack_d   = 1'b1;
                    p1_rdata_d = resp_data_s;
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = resp_data_s;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            p0_ack_q    <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= {DATA_W{1'b0}};
            p1_ack_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p0_err_q    <= p0_err_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_ack_q    <= p1_ack_d;
            p1_err_q    <= p1_err_d;
            p1_rdata_q  <= p1_rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign p0_ack     = p0_ack_q;
    assign p0_err     = p0_err_q;
    assign p0_rdata   = p0_rdata_q;
    assign p1_ack     = p1_ack_q;
    assign p1_err     = p1_err_q;
    assign p1_rdata   = p1_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_stall = p0_req & ~p0_ack_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller and two-port arbiter for the 64-bit data memory. It shares the single `data_memory` instance between the core's memory stage (port 0) and a debug/loader requester (port 1). It registers each request, drives the memory strobes for exactly one cycle, captures the read data and returns a one-cycle acknowledge. It sits between `mem_stage` and `data_memory` and produces the core stall signal while a core access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width

Ports:
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `p0_req`  input  1  core request; held stable until `p0_ack`
- `p0_we`  input  1  core request is a store (1) or load (0)
- `p0_addr`  input  ADDR_W  core byte address
- `p0_wdata`  input  DATA_W  core store data
- `p0_ack`  output  1  one-cycle completion pulse for port 0
- `p0_err`  output  1  valid with `p0_ack`; misaligned access
- `p0_rdata`  output  DATA_W  load data, valid with `p0_ack`
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_err`, `p1_rdata`: same as port 0, for the debug requester
- `core_stall`  output  1  `p0_req & ~p0_ack`, combinational
- `mem_read`  output  1  registered load strobe to `data_memory`
- `mem_write`  output  1  registered store strobe to `data_memory`
- `mem_addr`  output  ADDR_W  registered memory address
- `mem_wdata`  output  DATA_W  registered store data
- `mem_rdata`  input  DATA_W  `data_memory` read data, combinational from `mem_addr`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, latch the winner's `we`, `addr`, `wdata` and the grant index.
  - Aligned (`addr[2:0]==0`): go to ACCESS.
  - Misaligned: set error, go directly to RESP. No memory strobe is issued.
- ACCESS: `mem_read = ~we_q`, `mem_write = we_q`, both for exactly this one cycle. At the closing edge, capture `mem_rdata` into the response register (load) or clear it to 0 (store). Go to RESP.
- RESP: assert `pX_ack` for the granted port only, with `pX_rdata`/`pX_err` valid. Go to IDLE.
- Response data and error are driven only on the granted port. The ungranted port's outputs read 0.
- Arbitration with both requests in IDLE: see Configuration. A single requester always wins.
- A requester holds its request fields stable from raising `req` until it samples `ack`, and drops `req` in the cycle after `ack`. A `req` still high in IDLE after RESP is treated as a new request.
- An ungranted requester keeps waiting, with no timeout.

## Timing
- Request sampled at edge N (IDLE to ACCESS). Strobes are high during cycle N+1. `ack` is high during cycle N+2. Back in IDLE at N+3.
- Access latency is 2 cycles from the sampling edge to `ack`. Peak throughput is one access per 3 cycles.
- Misaligned request: `ack`+`err` during cycle N+1, with no strobe.
- Reset (asynchronous, active low):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Round-robin pointer resets to favour port 0.
  - Reset during ACCESS deasserts `mem_write` immediately; the write may or may not have committed.
  - No `ack` is issued for the abandoned request.
- `mem_read` and `mem_write` are never high together.
- At most one `ack` is high in any cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. A 1-bit `last_q` records the last granted port. On simultaneous requests the port not in `last_q` wins. `last_q` updates on every grant, including error grants.
- Not defined: fixed priority. Port 0 (core) always wins simultaneous requests, so port 1 can starve. `last_q` is not implemented.

## Test plan
- Core load: preload mem[0x40]=0xDEADBEEF_CAFEF00D. `p0_req` load at 0x40 -> `mem_read` pulses for 1 cycle, then `p0_ack` with `p0_rdata`=0xDEADBEEF_CAFEF00D exactly 2 cycles after sampling. `core_stall` is high until the `ack` cycle.
- Debug store then core load: p1 stores 0x1122334455667788 to 0x80, then p0 loads 0x80 -> `mem_write` pulses once, `p1_ack` with rdata=0, then `p0_rdata`=0x1122334455667788.
- Simultaneous requests, 4 rounds, both held high:
  - With `DMEM_ARB_RR_EN`: grants alternate p0, p1, p0, p1.
  - Without it: all four grants go to p0 and p1 is never acknowledged.
- Misaligned: p0 load at 0x43 -> `p0_ack`=1 and `p0_err`=1 one cycle after sampling. No `mem_read` or `mem_write` at any time.
- Reset mid-access: assert `rst_n`=0 during ACCESS of a p1 store -> `mem_write`, `mem_read`, both `ack`s and both `rdata` go to 0 immediately. After release, a p0 load completes normally with 2-cycle latency.
- Protocol checker (all tests): one-hot-or-zero on `ack`s, strobes mutually exclusive, each strobe exactly one cycle wide, no `ack` without a prior `req`.
